// File: rtl/lsu.sv
// Load/store unit: accepts one instruction at a time from execute, issues a
// single aligned 64-bit memory request for loads/stores, aligns and extends
// load data, and hands the result to writeback over valid/ready.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap
// instead of being rounded down to size alignment; adds port wb_exc).
module lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [4:0]      ex_rd,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            wb_exc,
`endif
  output logic            wb_we
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]      state_reg;
  logic [2:0]      funct3_reg;
  logic            is_load_reg;
  logic [2:0]      off_reg;

  logic [2:0]      size_m1;
  logic [7:0]      base_mask;
  logic [XLEN-1:0] rep_data;
  logic [2:0]      off;
  logic            misaligned;
  logic            is_mem;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  // Handshake outputs are pure decodes of the state register.
  assign ex_ready = (state_reg == IDLE);
  assign mem_req  = (state_reg == REQ);
  assign wb_valid = (state_reg == RESP);

  // Decode access size of the incoming instruction: lane mask and replicated store data.
  always_comb begin
    size_m1   = 3'd7;
    base_mask = 8'hFF;
    rep_data  = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin size_m1 = 3'd0; base_mask = 8'h01; rep_data = {(XLEN/8){ex_wdata[7:0]}};  end
      2'b01: begin size_m1 = 3'd1; base_mask = 8'h03; rep_data = {(XLEN/16){ex_wdata[15:0]}}; end
      2'b10: begin size_m1 = 3'd3; base_mask = 8'h0F; rep_data = {(XLEN/32){ex_wdata[31:0]}}; end
      default: begin size_m1 = 3'd7; base_mask = 8'hFF; rep_data = ex_wdata; end
    endcase
  end

  // Misaligned offsets are rounded down to the access size (only reached
  // without the trap option; with it, misaligned accesses never issue).
  assign is_mem     = ex_is_load | ex_is_store;
  assign misaligned = (ex_addr[2:0] & size_m1) != 3'd0;
  assign off        = ex_addr[2:0] & ~size_m1;

  // Shift the selected lane down and truncate/extend according to funct3.
  assign shifted = mem_rdata >> {off_reg, 3'b000};
  always_comb begin
    load_data = shifted;
    case (funct3_reg)
      3'b000: load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001: load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010: load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100: load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      3'b101: load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      3'b110: load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Main FSM: latch on accept, hold request until grant, capture response, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      funct3_reg  <= 3'd0;
      is_load_reg <= 1'b0;
      off_reg     <= 3'd0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= 8'h00;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      wb_we       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      wb_exc      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            funct3_reg  <= ex_funct3;
            is_load_reg <= ex_is_load;
            off_reg     <= off;
            mem_we      <= ex_is_store;
            mem_addr    <= {ex_addr[XLEN-1:3], 3'b000};
            mem_wdata   <= ex_is_store ? rep_data : '0;
            mem_wmask   <= ex_is_store ? (base_mask << off) : 8'h00;
            wb_rd       <= ex_rd;
            wb_data     <= ex_addr;
            wb_we       <= ~ex_is_store & (ex_rd != 5'd0);
            state_reg   <= is_mem ? REQ : RESP;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_exc      <= 1'b0;
            if (is_mem && misaligned) begin
              wb_exc    <= 1'b1;
              wb_we     <= 1'b0;
              state_reg <= RESP;
            end
`endif
          end
        end
        REQ: begin
          if (mem_gnt) state_reg <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_data   <= is_load_reg ? load_data : '0;
            state_reg <= RESP;
          end
        end
        default: begin
          if (wb_ready) state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  // Misalignment only matters when trapping; keep the net referenced.
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases from the test plan plus
// randomized instructions checked against a behavioural model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_we;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        wb_exc;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_funct3(ex_funct3), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef LSU_MISALIGN_TRAP_EN
    .wb_exc(wb_exc),
`endif
    .wb_we(wb_we)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] low_mask(input int s);
    if (s == 8) return '1;
    return (64'd1 << (s * 8)) - 64'd1;
  endfunction

  function automatic int eff_off(input logic [63:0] a, input int s);
    return (int'(a[2:0]) / s) * s;
  endfunction

  function automatic logic [63:0] st_data(input logic [63:0] wd, input int s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 8 / s; i++) r = r | ((wd & low_mask(s)) << (i * s * 8));
    return r;
  endfunction

  function automatic logic [63:0] ld_val(input logic [63:0] rdata, input int o, input int s,
                                         input logic [2:0] f3);
    logic [63:0] v;
    logic [63:0] m;
    m = low_mask(s);
    v = (rdata >> (o * 8)) & m;
    if (!f3[2] && s < 8 && v[s*8-1]) v = v | ~m;
    return v;
  endfunction

  // kind: 0 = pass-through, 1 = load, 2 = store
  task automatic do_op(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] f3,
                       input int kind, input logic [4:0] rd, input int gd, input int rvd,
                       input int wbd, input logic [63:0] rdata, output logic [63:0] got_data);
    int s, o;
    bit mem, trap, exp_we;
    logic [63:0] exp_data;
    logic [7:0] exp_mask;
    s = acc_size(f3);
    o = eff_off(a, s);
    mem = (kind != 0);
    trap = TRAP && mem && ((int'(a[2:0]) % s) != 0);
    exp_mask = 8'(((1 << s) - 1) << o);
    if (trap) begin exp_data = a; exp_we = 1'b0; end
    else if (kind == 0) begin exp_data = a; exp_we = (rd != 0); end
    else if (kind == 1) begin exp_data = ld_val(rdata, o, s, f3); exp_we = (rd != 0); end
    else begin exp_data = 64'd0; exp_we = 1'b0; end

    check("ex_ready_idle", ex_ready, 1);
    ex_valid = 1'b1; ex_addr = a; ex_wdata = wd; ex_funct3 = f3; ex_rd = rd;
    ex_is_load = (kind == 1); ex_is_store = (kind == 2);
    @(posedge clk); #1;
    // scramble inputs to prove the DUT latched them
    ex_valid = 1'b0; ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};
    ex_rd = 5'($urandom); ex_funct3 = 3'($urandom);

    if (mem && !trap) begin
      for (int i = 0; i <= gd; i++) begin
        check("mem_req", mem_req, 1);
        check("ex_ready_busy", ex_ready, 0);
        check("mem_addr", mem_addr, {a[63:3], 3'b000});
        check("mem_we", mem_we, (kind == 2));
        if (kind == 2) begin
          check("mem_wmask", mem_wmask, exp_mask);
          check("mem_wdata", mem_wdata, st_data(wd, s));
        end
        check("wb_valid_req", wb_valid, 0);
        mem_gnt = (i == gd);
        mem_rvalid = 1'b1;          // must be ignored while in REQ
        mem_rdata = ~rdata;
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0;
      for (int i = 0; i <= rvd; i++) begin
        check("mem_req_wait", mem_req, 0);
        check("wb_valid_wait", wb_valid, 0);
        check("ex_ready_wait", ex_ready, 0);
        mem_rvalid = (i == rvd);
        mem_rdata = (i == rvd) ? rdata : {$urandom, $urandom};
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
    end else begin
      check("mem_req_none", mem_req, 0);
    end

    got_data = wb_data;
    for (int i = 0; i <= wbd; i++) begin
      check("wb_valid", wb_valid, 1);
      check("wb_data", wb_data, exp_data);
      check("wb_we", wb_we, exp_we);
      check("wb_rd", wb_rd, rd);
      check("ex_ready_resp", ex_ready, 0);
      check("mem_req_resp", mem_req, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("wb_exc", wb_exc, trap);
`endif
      wb_ready = (i == wbd);
      @(posedge clk); #1;
    end
    wb_ready = 1'b0;
    check("wb_valid_drop", wb_valid, 0);
    check("ex_ready_back", ex_ready, 1);
    $display("op kind=%0d f3=%0d addr=%h rd=%0d stalls=%0d/%0d/%0d wb_data=%h",
             kind, f3, a, rd, gd, rvd, wbd, got_data);
  endtask

  logic [63:0] d;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_funct3 = '0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_ready", ex_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("rst_wb_exc", wb_exc, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(64'h1234, 64'd0, 3'b000, 0, 5'd5, 0, 0, 0, 64'd0, d);
    check("pass_data", d, 64'h1234);
    do_op(64'h1003, 64'd0, 3'b000, 1, 5'd7, 0, 0, 0, 64'h0000_0000_8000_0000, d);
    check("lb_data", d, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(64'h1003, 64'd0, 3'b100, 1, 5'd7, 0, 0, 0, 64'h0000_0000_8000_0000, d);
    check("lbu_data", d, 64'h80);
    do_op(64'h2002, 64'hABCD, 3'b001, 2, 5'd9, 1, 1, 0, 64'd0, d);
    check("sh_data", d, 64'd0);
    do_op(64'h4000, 64'd0, 3'b011, 1, 5'd3, 3, 2, 2, 64'h0123_4567_89AB_CDEF, d);
    check("ld_backpressure", d, 64'h0123_4567_89AB_CDEF);
    do_op(64'h3002, 64'd0, 3'b010, 1, 5'd4, 0, 0, 0, 64'h1122_3344_5566_7788, d);
    check("lw_misaligned", d, TRAP ? 64'h3002 : 64'h5566_7788);

    // Reset while in WAIT; a late response must be ignored
    ex_valid = 1'b1; ex_addr = 64'h5000; ex_funct3 = 3'b011; ex_is_load = 1'b1;
    ex_is_store = 1'b0; ex_rd = 5'd1;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("pre_rst_mem_req", mem_req, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ex_ready", ex_ready, 1);
    check("midrst_wb_valid", wb_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_wb_valid", wb_valid, 0);
      check("late_rsp_ex_ready", ex_ready, 1);
      check("late_rsp_mem_req", mem_req, 0);
      @(posedge clk); #1;
    end
    $display("reset-in-wait sequence done");

    // Randomized instructions
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom);
      if (kind == 2) f3[2] = 1'b0;
      do_op({$urandom, $urandom}, {$urandom, $urandom}, f3, kind, 5'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            {$urandom, $urandom}, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
